// File: rtl/vga_timing_gen_if.sv
// Raster bundle shared by the timing generator and downstream draw stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, sync/blank decode,
// start-of-frame / end-of-line pulses and a completed-frame counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               restart,
  vga_if.out                 out,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [10:0] h_nxt, v_nxt;
  logic        frame_wrap, line_end;
  logic        hsync_nxt, vsync_nxt, hblnk_nxt, vblnk_nxt;

  always_comb begin
    h_nxt      = hcount_q;
    v_nxt      = vcount_q;
    frame_wrap = 1'b0;
    line_end   = 1'b0;
    if (restart) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (en) begin
      if (hcount_q == H_LAST) begin
        h_nxt = '0;
        if (vcount_q == V_LAST) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = vcount_q + 11'd1;
        end
      end else begin
        h_nxt = hcount_q + 11'd1;
      end
      line_end = (h_nxt == H_LAST);
    end
  end

  // Decode from the next counts so sync/blank line up with the presented position.
  always_comb begin
    hblnk_nxt = (h_nxt >= H_ACT);
    vblnk_nxt = (v_nxt >= V_ACT);
    hsync_nxt = (h_nxt >= HS_BEG && h_nxt < HS_END) ? HS_POL : ~HS_POL;
    vsync_nxt = (v_nxt >= VS_BEG && v_nxt < VS_END) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q  <= '0;
      vcount_q  <= '0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      hblnk_q   <= 1'b0;
      vblnk_q   <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      hcount_q <= h_nxt;
      vcount_q <= v_nxt;
      hsync_q  <= hsync_nxt;
      vsync_q  <= vsync_nxt;
      hblnk_q  <= hblnk_nxt;
      vblnk_q  <= vblnk_nxt;
      sof      <= frame_wrap;
      eol      <= line_end;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign out.hcount = hcount_q;
  assign out.vcount = vcount_q;
  assign out.hsync  = hsync_q;
  assign out.vsync  = vsync_q;
  assign out.hblnk  = hblnk_q;
  assign out.vblnk  = vblnk_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default XGA timing, a 16x8 raster, and the same raster with
// inverted sync polarity, all driven from shared controls.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n, en, restart;

  vga_if big_if ();
  vga_if sm_if ();
  vga_if pol_if ();

  logic        big_sof, big_eol, sm_sof, sm_eol, pol_sof, pol_eol;
  logic [15:0] big_frame;
  logic [1:0]  sm_frame;
  logic [15:0] pol_frame;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_big (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
    .out(big_if), .sof(big_sof), .eol(big_eol), .frame_cnt(big_frame)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FRAME_W(2)
  ) u_sm (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
    .out(sm_if), .sof(sm_sof), .eol(sm_eol), .frame_cnt(sm_frame)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
    .out(pol_if), .sof(pol_sof), .eol(pol_eol), .frame_cnt(pol_frame)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sm_pos(input string tag, input int h, input int v);
    check({tag, "_h"}, 32'(sm_if.hcount), 32'(h));
    check({tag, "_v"}, 32'(sm_if.vcount), 32'(v));
  endtask

  initial begin
    int h, v;
    rst_n   = 1'b0;
    en      = 1'b0;
    restart = 1'b0;
    repeat (2) tick();

    // Reset values
    check("rst_big_h",     32'(big_if.hcount), 0);
    check("rst_big_v",     32'(big_if.vcount), 0);
    check("rst_big_hsync", 32'(big_if.hsync), 0);
    check("rst_big_vsync", 32'(big_if.vsync), 0);
    check("rst_big_hblnk", 32'(big_if.hblnk), 0);
    check("rst_big_vblnk", 32'(big_if.vblnk), 0);
    check("rst_big_sof",   32'(big_sof), 0);
    check("rst_big_eol",   32'(big_eol), 0);
    check("rst_big_frame", 32'(big_frame), 0);
    check("rst_pol_hsync", 32'(pol_if.hsync), 1);
    check("rst_pol_vsync", 32'(pol_if.vsync), 1);
    check("rst_pol_hblnk", 32'(pol_if.hblnk), 0);

    // Count a little, then reset asynchronously between edges
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (5) tick();
    check("cnt_big_h5", 32'(big_if.hcount), 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_big_h", 32'(big_if.hcount), 0);
    check("async_sm_h",  32'(sm_if.hcount), 0);
    rst_n = 1'b1;

    // Default timing hsync window edges
    tick();
    check("big_h1", 32'(big_if.hcount), 1);
    repeat (1046) tick();
    check("big_h1047",     32'(big_if.hcount), 1047);
    check("big_hs_1047",   32'(big_if.hsync), 0);
    check("big_hblnk1047", 32'(big_if.hblnk), 1);
    tick();
    check("big_h1048",   32'(big_if.hcount), 1048);
    check("big_hs_1048", 32'(big_if.hsync), 1);
    repeat (135) tick();
    check("big_hs_1183", 32'(big_if.hsync), 1);
    tick();
    check("big_h1184",   32'(big_if.hcount), 1184);
    check("big_hs_1184", 32'(big_if.hsync), 0);
    repeat (159) tick();
    check("big_h1343",   32'(big_if.hcount), 1343);
    check("big_eol1343", 32'(big_eol), 1);
    check("big_v_line0", 32'(big_if.vcount), 0);
    tick();
    check("big_h_wrap", 32'(big_if.hcount), 0);
    check("big_v_line1", 32'(big_if.vcount), 1);
    check("big_eol_off", 32'(big_eol), 0);

    // Small raster, five full frames with en held high
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 640; t++) begin
      tick();
      h = t % 16;
      v = (t / 16) % 8;
      check_sm_pos("sm", h, v);
      check("sm_hblnk", 32'(sm_if.hblnk), (h >= 8) ? 1 : 0);
      check("sm_vblnk", 32'(sm_if.vblnk), (v >= 4) ? 1 : 0);
      check("sm_hsync", 32'(sm_if.hsync), (h >= 10 && h <= 12) ? 1 : 0);
      check("sm_vsync", 32'(sm_if.vsync), (v >= 5 && v <= 6) ? 1 : 0);
      check("sm_eol",   32'(sm_eol), (h == 15) ? 1 : 0);
      check("sm_sof",   32'(sm_sof), (t % 128 == 0) ? 1 : 0);
      check("sm_frame", 32'(sm_frame), 32'((t / 128) % 4));
      check("pol_hsync", 32'(pol_if.hsync), (h >= 10 && h <= 12) ? 0 : 1);
      check("pol_vsync", 32'(pol_if.vsync), (v >= 5 && v <= 6) ? 0 : 1);
      check("pol_hblnk", 32'(pol_if.hblnk), (h >= 8) ? 1 : 0);
      check("pol_vblnk", 32'(pol_if.vblnk), (v >= 4) ? 1 : 0);
    end

    // Enable gating: sof then eol must last one clock when en drops
    en = 1'b0;
    tick();
    check("gate_sof_off", 32'(sm_sof), 0);
    check_sm_pos("gate_hold0", 0, 0);
    check("gate_frame", 32'(sm_frame), 1);
    en = 1'b1;
    repeat (15) tick();
    check_sm_pos("gate_pre", 15, 0);
    check("gate_eol_on", 32'(sm_eol), 1);
    en = 1'b0;
    tick();
    check("gate_eol_off", 32'(sm_eol), 0);
    check_sm_pos("gate_hold1", 15, 0);
    check("gate_hblnk", 32'(sm_if.hblnk), 1);
    tick();
    check("gate_eol_off2", 32'(sm_eol), 0);
    check_sm_pos("gate_hold2", 15, 0);
    en = 1'b1;
    tick();
    check_sm_pos("gate_resume", 0, 1);
    check("gate_eol_resume", 32'(sm_eol), 0);

    // Restart at (13,6) inside vsync, with en also high
    repeat (93) tick();
    check_sm_pos("rs_pre", 13, 6);
    check("rs_pre_vsync", 32'(sm_if.vsync), 1);
    restart = 1'b1;
    tick();
    check_sm_pos("rs", 0, 0);
    check("rs_hsync", 32'(sm_if.hsync), 0);
    check("rs_vsync", 32'(sm_if.vsync), 0);
    check("rs_hblnk", 32'(sm_if.hblnk), 0);
    check("rs_vblnk", 32'(sm_if.vblnk), 0);
    check("rs_sof",   32'(sm_sof), 0);
    check("rs_eol",   32'(sm_eol), 0);
    check("rs_frame", 32'(sm_frame), 1);
    check("rs_pol_hsync", 32'(pol_if.hsync), 1);
    check("rs_pol_vsync", 32'(pol_if.vsync), 1);
    restart = 1'b0;
    tick();
    check_sm_pos("rs_after", 1, 0);

    // Restart with en low, just before an eol would fire
    repeat (13) tick();
    check_sm_pos("rs2_pre", 14, 0);
    restart = 1'b1;
    en      = 1'b0;
    tick();
    check_sm_pos("rs2", 0, 0);
    check("rs2_eol", 32'(sm_eol), 0);
    restart = 1'b0;
    en      = 1'b1;
    tick();
    check_sm_pos("rs2_after", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Fully parametrised VGA/XGA raster timing generator, the successor to the fixed 1024x768 timing block.
- Produces horizontal and vertical counters, sync and blanking over the existing vga_if bundle, plus frame-start and end-of-line pulses and a frame counter.
- Adds a pixel-rate clock enable, a synchronous restart and per-axis sync polarity.
- Sits at the head of the video pipeline; every downstream draw stage consumes its vga_if output.

Parameters:
- H_ACTIVE, 1024, visible pixels per line.
- H_FP, 24, horizontal front porch (pixels).
- H_SYNC, 136, hsync width (pixels).
- H_BP, 160, horizontal back porch (pixels). H_TOTAL = sum of H_* = 1344.
- V_ACTIVE, 768, visible lines.
- V_FP, 3, vertical front porch (lines).
- V_SYNC, 6, vsync width (lines).
- V_BP, 29, vertical back porch (lines). V_TOTAL = sum of V_* = 806.
- HS_POL, 1, hsync active level (1 = active-high).
- VS_POL, 1, vsync active level.
- FRAME_W, 16, frame counter width.

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  asynchronous reset, active-low.
- en  in  1  pixel enable; the raster advances only on clk edges with en=1.
- restart  in  1  synchronous restart to (0,0).
- out  vga_if.out  -  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk.
- sof  out  1  start-of-frame pulse.
- eol  out  1  end-of-line pulse.
- frame_cnt  out  FRAME_W  completed-frame count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - hcount=0, vcount=0, hblnk=0, vblnk=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - sof=0, eol=0, frame_cnt=0.
- All outputs are registered. hsync, vsync, hblnk and vblnk are computed from next-state counts, so they always describe the hcount/vcount presented in the same cycle (zero skew).
- Advance (en=1, restart=0):
  - hcount increments.
  - When hcount==H_TOTAL-1, hcount goes to 0 and vcount increments.
  - When both are at their maximum, (H_TOTAL-1, V_TOTAL-1), the raster goes to (0,0).
- Hold (en=0): counters, sync, blank and frame_cnt hold. sof and eol are forced to 0.
- Decode:
  - hblnk = hcount >= H_ACTIVE.
  - vblnk = vcount >= V_ACTIVE.
  - hsync = HS_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vsync: same rule on vcount with the V_* parameters and VS_POL.
- sof: high for exactly one clk when the presented position became (0,0) through a frame wrap.
  - Not asserted after reset or after restart.
- eol: high for exactly one clk when the presented hcount became H_TOTAL-1.
- frame_cnt: increments in the same cycle sof rises; wraps modulo 2^FRAME_W.
- restart=1 (overrides en):
  - Next cycle presents (0,0) with decode outputs consistent with (0,0).
  - sof=0, eol=0, frame_cnt unchanged.
  - Valid at any point in the frame, including during sync.
- Counters are 11 bits. Elaboration shall fail (assertion) if H_TOTAL > 2048 or V_TOTAL > 2048, or if any porch/sync parameter is 0.

Test Plan:
1. Reset and defaults: assert rst_n=0 mid-count, check outputs asynchronously return to reset values. Release with en=1: hcount counts 0,1,2…; at hcount 1047->1048 hsync rises in the same cycle; at hcount 1183->1184 it falls.
2. Small raster, en=1 continuously: H 8/2/3/3 (total 16), V 4/1/2/1 (total 8).
   - hblnk=1 for hcount 8..15; hsync=1 for hcount 10..12.
   - eol pulses at hcount 15; vcount steps at the 15->0 wrap.
   - vsync=1 for vcount 5..6.
3. Frame wrap, small raster: after 128 enabled cycles the raster returns to (0,0) with sof=1 for one clk and frame_cnt=1. With FRAME_W=2, frame_cnt reads 0 after 4 frames.
4. Enable gating: en toggles 1,0,0,1. Each value is held across the en=0 cycles. An eol or sof pulse lasts one clk even if en drops right after it.
5. Restart: restart=1 at (13,6) during vsync. Next cycle shows (0,0) with hsync, vsync, hblnk, vblnk all 0, sof=0 and frame_cnt unchanged. restart and en both high together: restart wins.
6. Polarity: HS_POL=0, VS_POL=0. Reset gives hsync=vsync=1. Syncs go to 0 only inside their windows; blanking is unaffected.
